// File: rtl/dot_motion_ctrl_if.sv
// Pin bundle between the flappy-dot motion controller and its neighbours.
// Carries the raw button, renderer collision flag and dot position/state outputs.
// The slave side is the controller; the master side drives button/collide and observes.
interface dot_motion_ctrl_if #(
    parameter int Y_W = 7
);
    logic           i_key_press;
    logic           i_collide;
    logic [Y_W-1:0] o_dot_y;
    logic           o_up;
    logic [1:0]     o_state;
    logic           o_game_over;
    logic           o_move_tick;

    modport slave (
        input  i_key_press,
        input  i_collide,
        output o_dot_y,
        output o_up,
        output o_state,
        output o_game_over,
        output o_move_tick
    );

    modport master (
        output i_key_press,
        output i_collide,
        input  o_dot_y,
        input  o_up,
        input  o_state,
        input  o_game_over,
        input  o_move_tick
    );
endinterface

// File: rtl/dot_motion_ctrl.sv
// Flappy-dot game controller: button->flap events, flight timer, paced vertical steps, IDLE/FLY/FALL/DEAD.
// Latency: a button press changes state on the 3rd clock edge after key_press falls; other outputs are registered.
// No backpressure: button and collide are sampled every cycle, outputs update unconditionally.
module dot_motion_ctrl #(
    parameter int FLY_TICKS  = 35000000,
    parameter int STEP_TICKS = 1000000,
    parameter int Y_MAX      = 119,
    parameter int Y_START    = 60,
    parameter int Y_W        = 7
) (
    input  logic              i_clk50,
    input  logic              i_resetn,
    dot_motion_ctrl_if.slave  io_bus
);
    localparam int CW = (STEP_TICKS > 2) ? $clog2(STEP_TICKS) : 1;

    localparam logic [CW-1:0]  STEP_LAST = CW'(STEP_TICKS - 1);
    localparam logic [27:0]    FLY_LOAD  = 28'(FLY_TICKS - 1);
    localparam logic [Y_W-1:0] Y_START_N = Y_W'(Y_START);
    localparam logic [Y_W-1:0] Y_MAX_N   = Y_W'(Y_MAX);
    localparam logic [Y_W:0]   Y_MAX_W   = (Y_W + 1)'(Y_MAX);
    localparam logic [Y_W-1:0] Y_ONE     = Y_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_FALL = 2'd2,
        S_DEAD = 2'd3
    } state_t;

    state_t         r_state;
    logic [Y_W-1:0] r_dot_y;
    logic           r_up;
    logic           r_game_over;
    logic           r_move_tick;
    logic [27:0]    r_timer;
    logic [CW-1:0]  r_step_cnt;
    logic           r_s1;
    logic           r_s2;
    logic           r_kp;

    logic           w_press;
    logic           w_run;
    logic           w_step;
    logic [Y_W-1:0] w_y_up;
    logic [Y_W:0]   w_y_dn_wide;
    logic           w_floor;
    logic [Y_W-1:0] w_y_fall;

    // Two-flop synchronizer for the asynchronous button, then an edge register; all idle high (released).
    always_ff @(posedge i_clk50 or negedge i_resetn) begin
        if (!i_resetn) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_kp <= 1'b1;
        end else begin
            r_s1 <= io_bus.i_key_press;
            r_s2 <= r_s1;
            r_kp <= r_s2;
        end
    end

    // A press is the single cycle where the synchronized button has just gone low.
    assign w_press     = r_kp & ~r_s2;
    assign w_run       = (r_state == S_FLY) || (r_state == S_FALL);
    assign w_step      = w_run && (r_step_cnt == STEP_LAST);
    assign w_y_up      = (r_dot_y == '0) ? '0 : (r_dot_y - Y_ONE);
    assign w_y_dn_wide = {1'b0, r_dot_y} + {{Y_W{1'b0}}, 1'b1};
    assign w_floor     = (w_y_dn_wide >= Y_MAX_W);
    assign w_y_fall    = w_floor ? Y_MAX_N : w_y_dn_wide[Y_W-1:0];

    // Game FSM with step pacing and flight timer; priority collide > floor > press > expiry > step.
    always_ff @(posedge i_clk50 or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state     <= S_IDLE;
            r_dot_y     <= Y_START_N;
            r_up        <= 1'b0;
            r_game_over <= 1'b0;
            r_move_tick <= 1'b0;
            r_timer     <= '0;
            r_step_cnt  <= '0;
        end else begin
            r_move_tick <= 1'b0;

            // Step counter only advances while the dot is in the air.
            if (w_run) begin
                r_step_cnt <= w_step ? '0 : (r_step_cnt + 1'b1);
            end

            // Flight timer counts down only while climbing; loads below override this.
            if (r_state == S_FLY && r_timer != '0) begin
                r_timer <= r_timer - 28'd1;
            end

            case (r_state)
                S_IDLE: begin
                    r_dot_y <= Y_START_N;
                    if (w_press) begin
                        r_state    <= S_FLY;
                        r_up       <= 1'b1;
                        r_timer    <= FLY_LOAD;
                        r_step_cnt <= '0;
                    end
                end
                S_FLY, S_FALL: begin
                    if (io_bus.i_collide) begin
                        // Collision kills immediately and suppresses any step this edge.
                        r_state     <= S_DEAD;
                        r_up        <= 1'b0;
                        r_game_over <= 1'b1;
                    end else begin
                        // The step direction follows the state the dot was in before this edge.
                        if (w_step) begin
                            r_move_tick <= 1'b1;
                            r_dot_y     <= (r_state == S_FLY) ? w_y_up : w_y_fall;
                        end
                        if (r_state == S_FALL && w_step && w_floor) begin
                            r_state     <= S_DEAD;
                            r_up        <= 1'b0;
                            r_game_over <= 1'b1;
                        end else if (w_press) begin
                            r_state <= S_FLY;
                            r_up    <= 1'b1;
                            r_timer <= FLY_LOAD;
                        end else if (r_state == S_FLY && r_timer == '0) begin
                            r_state <= S_FALL;
                            r_up    <= 1'b0;
                        end
                    end
                end
                S_DEAD: begin
                    if (w_press) begin
                        r_state     <= S_IDLE;
                        r_dot_y     <= Y_START_N;
                        r_game_over <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.o_dot_y     = r_dot_y;
    assign io_bus.o_up        = r_up;
    assign io_bus.o_state     = r_state;
    assign io_bus.o_game_over = r_game_over;
    assign io_bus.o_move_tick = r_move_tick;
endmodule

// File: doc/dot_motion_ctrl.md
Name: dot_motion_ctrl

Overview:
Game-level motion controller for the flappy dot. Turns the raw active-low push-button into single flap events, times each flight, and steps the dot's vertical position up or down at a fixed rate. Runs the IDLE/FLY/FALL/DEAD game state machine and feeds dot_y to the VGA renderer. Takes a collision flag back from the renderer. Supersedes the standalone flight timer as the single owner of the up/down decision.

Parameters:
FLY_TICKS, 35000000, clk50 cycles of upward motion after each flap (1..2^28-1)
STEP_TICKS, 1000000, clk50 cycles between one-pixel moves (>=2)
Y_MAX, 119, floor row; reaching it ends the game
Y_START, 60, dot row after reset and on restart
Y_W, 7, width of dot_y

Ports:
clk50  in  1  system clock, 50 MHz
resetn  in  1  reset, asynchronous, active-low
key_press  in  1  raw push-button, active-low (0 = pressed), asynchronous to clk50
collide  in  1  renderer collision flag, synchronous to clk50, level
dot_y  out  Y_W  dot row, 0 = top of screen
up  out  1  1 while state==FLY
state  out  2  IDLE=0, FLY=1, FALL=2, DEAD=3
game_over  out  1  1 while state==DEAD
move_tick  out  1  one-cycle pulse on each position step

Behaviour:
- Reset: resetn low asynchronously forces the following values:
  - state=IDLE, dot_y=Y_START, up=0, game_over=0, move_tick=0.
  - Flight timer=0, step counter=0.
  - Both synchronizer flops and the edge register=1 (released).
- Press detection:
  - key_press passes through a 2-FF synchronizer (s1, s2), then an edge register kp<=s2.
  - press = kp & ~s2, combinational, one cycle per falling edge.
  - The state update from a press lands on the 3rd rising clk50 edge after key_press falls.
  - Holding the key gives exactly one press. Bounce produces extra presses; no debouncing is done here.
- Step counter:
  - Runs only in FLY/FALL. Counts 0..STEP_TICKS-1 and wraps.
  - Cleared to 0 on entry to FLY from IDLE.
  - move_tick is registered and is 1 in the cycle after the counter equals STEP_TICKS-1. It is 0 in IDLE/DEAD.
  - All dot_y changes happen on the edge where move_tick goes high.
- Flight timer: 28-bit down-counter. Loaded with FLY_TICKS-1 on every press in IDLE/FLY/FALL. Decrements each cycle in FLY.
- IDLE:
  - dot_y held at Y_START.
  - press -> FLY, load timer, clear step counter.
  - collide is ignored.
- FLY:
  - Each step: dot_y <= dot_y-1, saturating at 0. The ceiling is not fatal.
  - Timer==0 with no press -> FALL.
  - press -> stay FLY and reload the timer; press wins over expiry.
- FALL:
  - Each step: dot_y <= dot_y+1.
  - If the new value is >= Y_MAX, dot_y=Y_MAX and state -> DEAD on the same edge.
  - press -> FLY and load the timer. The step counter is not cleared.
- DEAD:
  - dot_y frozen, game_over=1, up=0.
  - press -> IDLE with dot_y=Y_START.
- collide:
  - collide=1 in FLY/FALL -> DEAD on the next edge.
  - collide has priority over press, timer expiry and floor.
  - A step on that same edge is not applied.
- Priority in FLY/FALL: collide > floor > press > timer expiry > step.
- Outputs: up, game_over and state are registered and consistent with each other in every cycle.

Test Plan:
Bench parameters: FLY_TICKS=20, STEP_TICKS=4, Y_MAX=15, Y_START=8, Y_W=4.

1. Assert resetn=0 mid-cycle -> without waiting for a clock edge: state=0, dot_y=8, up=0, game_over=0, move_tick=0. Release and idle 50 cycles -> nothing changes.
2. key_press low 1 cycle in IDLE -> state=1, up=1 on the 3rd edge. move_tick every 4 cycles. dot_y goes 7,6,5,4,3. After 20 cycles state=2, up=0. dot_y climbs to 15 in 12 steps -> state=3, game_over=1, dot_y stays 15.
3. key_press held low 200 cycles from IDLE -> single flight: FALL 20 cycles after entering FLY, no reload while held.
4. A press every 16 cycles from IDLE -> state stays FLY, dot_y saturates at 0 and holds, game_over stays 0.
5. collide=1 in FALL at dot_y=10, same cycle as a press -> DEAD next edge, dot_y=10, up=0. A later press -> IDLE with dot_y=8. A further press -> FLY.
6. resetn pulsed low during FLY with dot_y=5 -> immediately IDLE, dot_y=8, up=0, timer cleared. A press after release starts a fresh 20-cycle flight.
